round_key_store: RTL and testbench

// - Receiving end of the key_expansion round-key write stream: captures the key_out/key_addr sequence into a
//   15x128 register file and tracks completeness against the latched key type.
// - Serves round keys to the cipher datapath over a valid/ready stream: ascending for encrypt, descending for decrypt.
// - Sits between key_expansion and the round datapath; rekeying aborts any stream in flight.

---
 rtl/round_key_store_pkg.sv | 26 ++
 rtl/round_key_store_if.sv | 13 +
 rtl/round_key_store_rk_regfile.sv | 30 +++
 rtl/round_key_store.sv | 158 +++++++++++++++
 tb/tb_round_key_store.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/round_key_store_pkg.sv
// Shared AES key-schedule types: key-size encoding, round-key word and the
// last round-key index for each key size.
package round_key_store_pkg;

   typedef enum logic [1:0] {
      AES128  = 2'b00,
      AES192  = 2'b01,
      AES256  = 2'b10,
      ILLEGAL = 2'b11
   } key_type_e;

   typedef logic [127:0] round_key_t;

   localparam logic [3:0] LAST_IDX_128 = 4'd10;
   localparam logic [3:0] LAST_IDX_192 = 4'd12;
   localparam logic [3:0] LAST_IDX_256 = 4'd14;

   function automatic logic [3:0] last_idx(key_type_e kt);
      case (kt)
         AES128:  return LAST_IDX_128;
         AES192:  return LAST_IDX_192;
         default: return LAST_IDX_256;
      endcase
   endfunction

endpackage

// File: rtl/round_key_store_if.sv
// Round-key valid/ready stream from the key store to the cipher datapath.
interface round_key_store_if #(
   parameter int KEY_W = 128
);
   logic             rk_valid;
   logic             rk_ready;
   logic [KEY_W-1:0] rk_data;
   logic [3:0]       rk_round;
   logic             rk_last;

   modport master (output rk_valid, rk_data, rk_round, rk_last, input rk_ready);
   modport slave  (input rk_valid, rk_data, rk_round, rk_last, output rk_ready);
endinterface

// File: rtl/round_key_store_rk_regfile.sv
// Round-key storage: one write port, one registered read port whose output
// holds its value until the next read enable.
module rk_regfile #(
   parameter int KEY_W = 128,
   parameter int DEPTH = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [3:0]       waddr,
   input  logic [KEY_W-1:0] wdata,
   input  logic             re,
   input  logic [3:0]       raddr,
   output logic [KEY_W-1:0] rdata
);

   logic [KEY_W-1:0] mem [DEPTH];

   // NOTE: storage has no reset; validity is tracked by the owner's mask, so
   // clearing 15x128 flops would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/round_key_store.sv
// Captures the key-expansion write stream into a register file, checks the key
// set for completeness and serves it as an ascending or descending key sweep.
module round_key_store
   import round_key_store_pkg::*;
#(
   parameter int KEY_W  = 128,
   parameter int NUM_RK = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              key_type,
   input  logic                    key_we,
   input  logic [3:0]              key_addr,
   input  logic [KEY_W-1:0]        key_out,
   input  logic                    key_loaded,
   input  logic                    rd_start,
   input  logic                    rd_decrypt,
   output logic                    keys_ready,
   output logic                    err,
   round_key_store_if.master       rk
);

   typedef enum logic [1:0] {IDLE, LOADING, READY, STREAM} rks_state_e;

   rks_state_e        state;
   key_type_e         type_q;
   key_type_e         in_type;
   key_type_e         eff_type;
   logic [NUM_RK-1:0] mask;
   logic [NUM_RK-1:0] mask_nxt;
   logic [NUM_RK-1:0] wr_bit;
   logic [NUM_RK-1:0] need;
   logic              dec_q;
   logic              load_start;
   logic              wr_en;
   logic              loaded_ok;
   logic              handshake;
   logic              rd_en;
   logic [3:0]        eff_last;
   logic [3:0]        cur_last;
   logic [3:0]        start_idx;
   logic [3:0]        nxt_idx;
   logic [3:0]        rd_addr;

   assign in_type = key_type_e'(key_type);

   // Any write outside LOADING starts a fresh load using the presented type.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      load_start = key_we && (state != LOADING);
      eff_type   = load_start ? in_type : type_q;
      eff_last   = last_idx(eff_type);
      wr_en      = key_we && (eff_type != ILLEGAL) && (key_addr <= eff_last);
      wr_bit     = wr_en ? (NUM_RK'(1) << key_addr) : '0;
      mask_nxt   = (load_start ? '0 : mask) | wr_bit;
      cur_last   = last_idx(type_q);
      need       = '0;
      for (int i = 0; i < NUM_RK; i++) need[i] = (i <= int'(cur_last));
      loaded_ok  = (mask_nxt & need) == need;
      handshake  = rk.rk_valid && rk.rk_ready;
      start_idx  = rd_decrypt ? cur_last : 4'd0;
      nxt_idx    = dec_q ? rk.rk_round - 4'd1 : rk.rk_round + 4'd1;
      rd_en      = 1'b0;
      rd_addr    = start_idx;
      if (!key_we) begin
         if (state == READY && rd_start) begin
            rd_en   = 1'b1;
            rd_addr = start_idx;
         end else if (state == STREAM && handshake && !rk.rk_last) begin
            rd_en   = 1'b1;
            rd_addr = nxt_idx;
         end
      end
   end

   rk_regfile #(.KEY_W(KEY_W), .DEPTH(NUM_RK)) u_rf (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en),
      .waddr (key_addr),
      .wdata (key_out),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rk.rk_data)
   );

   // NOTE: state registers use non-blocking assignments so every branch sees
   // the pre-edge values of state, mask and rk_round.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         type_q      <= AES128;
         mask        <= '0;
         err         <= 1'b0;
         keys_ready  <= 1'b0;
         dec_q       <= 1'b0;
         rk.rk_valid <= 1'b0;
         rk.rk_round <= '0;
         rk.rk_last  <= 1'b0;
      end else if (load_start) begin
         // Rekeying aborts any sweep and drops the stored set.
         keys_ready  <= 1'b0;
         rk.rk_valid <= 1'b0;
         rk.rk_last  <= 1'b0;
         if (in_type == ILLEGAL) begin
            err   <= 1'b1;
            state <= IDLE;
         end else begin
            type_q <= in_type;
            mask   <= mask_nxt;
            err    <= !wr_en;
            state  <= LOADING;
         end
      end else begin
         case (state)
            LOADING: begin
               if (key_we) begin
                  mask <= mask_nxt;
                  if (!wr_en) err <= 1'b1;
               end
               if (key_loaded) begin
                  if (loaded_ok) begin
                     state      <= READY;
                     keys_ready <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            READY: begin
               if (rd_start) begin
                  state       <= STREAM;
                  keys_ready  <= 1'b0;
                  dec_q       <= rd_decrypt;
                  rk.rk_valid <= 1'b1;
                  rk.rk_round <= start_idx;
                  rk.rk_last  <= 1'b0;
               end
            end
            STREAM: begin
               if (handshake) begin
                  if (rk.rk_last) begin
                     state       <= READY;
                     keys_ready  <= 1'b1;
                     rk.rk_valid <= 1'b0;
                     rk.rk_last  <= 1'b0;
                  end else begin
                     rk.rk_round <= nxt_idx;
                     rk.rk_last  <= dec_q ? (nxt_idx == 4'd0) : (nxt_idx == cur_last);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: a queue-based key-store model checked
// every cycle, plus literal expectations from the FIPS-197 AES-128 schedule.
module tb_round_key_store;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [1:0]   key_type = 2'b00;
   logic         key_we = 1'b0;
   logic [3:0]   key_addr = 4'd0;
   logic [127:0] key_out = '0;
   logic         key_loaded = 1'b0;
   logic         rd_start = 1'b0;
   logic         rd_decrypt = 1'b0;
   logic         keys_ready;
   logic         err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   round_key_store_if #(.KEY_W(128)) rk_bus ();

   round_key_store #(.KEY_W(128), .NUM_RK(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_type   (key_type),
      .key_we     (key_we),
      .key_addr   (key_addr),
      .key_out    (key_out),
      .key_loaded (key_loaded),
      .rd_start   (rd_start),
      .rd_decrypt (rd_decrypt),
      .keys_ready (keys_ready),
      .err        (err),
      .rk         (rk_bus)
   );

   logic [127:0] fips [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

   function automatic logic [127:0] pat(int t, int i);
      return {8'(t), 8'(i), 16'h5a5a, 32'(i * 7 + t), 64'hfedcba9876543210 + 64'(i)};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: stored keys, written set, and the queue of round indices still to deliver.
   logic [127:0] m_rf [15];
   logic [14:0]  m_written;
   int           m_type;
   bit           m_loading, m_ready, m_err;
   int           q[$];

   always @(posedge clk or negedge rst) begin
      bit was_loading;
      bit full;
      int last;
      if (!rst) begin
         m_loading = 0; m_ready = 0; m_err = 0; m_type = 0; m_written = '0;
         q.delete();
      end else begin
         was_loading = m_loading;
         if (key_we) begin
            if (!m_loading) begin
               q.delete();
               m_ready = 0;
               if (key_type == 2'b11) m_err = 1;
               else begin
                  m_type = int'(key_type); m_written = '0; m_err = 0; m_loading = 1;
               end
            end
            if (m_loading) begin
               if (int'(key_addr) <= 10 + 2 * m_type) begin
                  m_rf[key_addr] = key_out;
                  m_written[key_addr] = 1'b1;
               end else m_err = 1;
            end
         end else if (q.size() > 0) begin
            if (rk_bus.rk_ready) begin
               void'(q.pop_front());
               if (q.size() == 0) m_ready = 1;
            end
         end else if (m_ready && rd_start) begin
            m_ready = 0;
            last = 10 + 2 * m_type;
            for (int k = 0; k <= last; k++) q.push_back(rd_decrypt ? last - k : k);
         end
         if (was_loading && m_loading && key_loaded) begin
            full = 1;
            for (int k = 0; k <= 10 + 2 * m_type; k++) if (!m_written[k]) full = 0;
            if (full) begin m_loading = 0; m_ready = 1; end
            else m_err = 1;
         end
      end
   end

   always @(negedge clk) begin
      check("keys_ready", keys_ready, m_ready);
      check("err", err, m_err);
      check("rk_valid", rk_bus.rk_valid, q.size() > 0);
      check("rk_last", rk_bus.rk_last, q.size() == 1);
      if (q.size() > 0) begin
         check("rk_round", rk_bus.rk_round, q[0]);
         check("rk_data", rk_bus.rk_data, m_rf[q[0]]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int t, input int a, input logic [127:0] d);
      key_we = 1'b1; key_type = 2'(t); key_addr = 4'(a); key_out = d;
      tick();
      key_we = 1'b0;
   endtask

   task automatic pulse_loaded();
      key_loaded = 1'b1;
      tick();
      key_loaded = 1'b0;
   endtask

   // Runs one sweep to completion; ends at the negedge of the bubble cycle.
   task automatic sweep(input bit dec, input bit toggle, output int beats, output int first_r,
                        output int last_r, output int last_cnt, output int last_beat,
                        output logic [127:0] r10, output bit stable_ok, output bit bubble_ready);
      bit           done = 0;
      bit           prev_stall = 0;
      logic [127:0] prev_data = '0;
      beats = 0; first_r = -1; last_r = -1; last_cnt = 0; last_beat = 0;
      r10 = '0; stable_ok = 1; bubble_ready = 0;
      rd_start = 1'b1; rd_decrypt = dec; rk_bus.rk_ready = 1'b1;
      tick();
      rd_start = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (rk_bus.rk_valid) begin
            if (first_r < 0) first_r = int'(rk_bus.rk_round);
            if (prev_stall && rk_bus.rk_data !== prev_data) stable_ok = 0;
            if (rk_bus.rk_ready) begin
               beats++;
               if (rk_bus.rk_round == 4'd10) r10 = rk_bus.rk_data;
               if (rk_bus.rk_last) begin
                  last_cnt++; last_r = int'(rk_bus.rk_round); last_beat = beats;
               end
            end
            prev_stall = !rk_bus.rk_ready;
            prev_data  = rk_bus.rk_data;
         end else if (beats > 0) begin
            bubble_ready = keys_ready;
            done = 1;
            break;
         end
         tick();
         if (toggle) rk_bus.rk_ready = ~rk_bus.rk_ready;
      end
      check("sweep completes within bound", done, 1);
      rk_bus.rk_ready = 1'b1;
   endtask

   initial begin
      int beats, first_r, last_r, last_cnt, last_beat;
      logic [127:0] r10;
      bit stable_ok, bubble_ready, found;

      rk_bus.rk_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset keys_ready", keys_ready, 0);
      check("reset err", err, 0);
      check("reset rk_valid", rk_bus.rk_valid, 0);
      check("reset rk_data", rk_bus.rk_data, 0);
      check("reset rk_round", rk_bus.rk_round, 0);
      check("reset rk_last", rk_bus.rk_last, 0);
      tick();
      rst = 1'b1;
      tick();

      // AES-128 load and encrypt sweep
      for (int i = 0; i <= 10; i++) wr(0, i, fips[i]);
      pulse_loaded();
      @(negedge clk);
      check("aes128 loaded keys_ready", keys_ready, 1);
      check("aes128 loaded err", err, 0);
      tick();
      sweep(0, 0, beats, first_r, last_r, last_cnt, last_beat, r10, stable_ok, bubble_ready);
      check("enc beats", beats, 11);
      check("enc first round", first_r, 0);
      check("enc rk_last count", last_cnt, 1);
      check("enc rk_last beat", last_beat, 11);
      check("enc round10 data", r10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("enc bubble keys_ready", bubble_ready, 1);
      tick();

      // AES-256 decrypt sweep with consumer stalls
      for (int i = 0; i <= 14; i++) wr(2, i, pat(2, i));
      pulse_loaded();
      sweep(1, 1, beats, first_r, last_r, last_cnt, last_beat, r10, stable_ok, bubble_ready);
      check("dec beats", beats, 15);
      check("dec first round", first_r, 14);
      check("dec rk_last round", last_r, 0);
      check("dec rk_last count", last_cnt, 1);
      check("dec data stable in stalls", stable_ok, 1);
      tick();

      // AES-192 with a hole at index 7, then filled while key_loaded held
      for (int i = 0; i <= 12; i++) if (i != 7) wr(1, i, pat(1, i));
      key_loaded = 1'b1;
      tick();
      @(negedge clk);
      check("aes192 hole err", err, 1);
      check("aes192 hole keys_ready", keys_ready, 0);
      tick();
      wr(1, 7, pat(1, 7));
      key_loaded = 1'b0;
      @(negedge clk);
      check("aes192 filled keys_ready", keys_ready, 1);
      tick();

      // New load coinciding with rd_start: write wins, err clears
      rd_start = 1'b1;
      wr(0, 0, fips[0]);
      rd_start = 1'b0;
      @(negedge clk);
      check("reload err cleared", err, 0);
      check("reload rk_valid", rk_bus.rk_valid, 0);
      check("reload keys_ready", keys_ready, 0);
      tick();
      for (int i = 1; i <= 10; i++) begin
         wr(0, i, fips[i]);
         if (i == 5) begin
            wr(0, 12, 128'hbadbadbadbadbadbadbadbadbadbadba);
            @(negedge clk);
            check("aes128 addr12 err", err, 1);
            tick();
         end
      end
      pulse_loaded();

      // Abort an encrypt sweep at beat 5 with a new key write
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      found = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rk_bus.rk_valid && rk_bus.rk_round == 4'd4) begin found = 1; break; end
         tick();
      end
      check("abort reached beat 5", found, 1);
      key_we = 1'b1; key_type = 2'b00; key_addr = 4'd0; key_out = fips[0];
      tick();
      key_we = 1'b0;
      @(negedge clk);
      check("abort rk_valid", rk_bus.rk_valid, 0);
      check("abort keys_ready", keys_ready, 0);
      tick();
      for (int i = 1; i <= 10; i++) wr(0, i, fips[i]);
      pulse_loaded();

      // Asynchronous reset mid-sweep
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      check("async rst rk_valid", rk_bus.rk_valid, 0);
      check("async rst rk_round", rk_bus.rk_round, 0);
      check("async rst rk_data", rk_bus.rk_data, 0);
      check("async rst rk_last", rk_bus.rk_last, 0);
      check("async rst keys_ready", keys_ready, 0);
      check("async rst err", err, 0);
      tick();
      rst = 1'b1;
      tick();

      // Illegal key type, then a legal load clears err
      wr(3, 0, 128'h1);
      @(negedge clk);
      check("illegal type err", err, 1);
      check("illegal type keys_ready", keys_ready, 0);
      tick();
      wr(0, 0, fips[0]);
      @(negedge clk);
      check("legal load clears err", err, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1);
   end

endmodule
